// File: rtl/unidade_multdiv_pkg.sv
// unidade_multdiv_pkg: funct codes and FSM state encoding for the multiply/divide unit
package unidade_multdiv_pkg;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;
endpackage

// File: rtl/unidade_multdiv_passo.sv
// multdiv_passo: one shift-add multiply step or one restoring-divide step on a 2*WIDTH accumulator
module multdiv_passo #(
  parameter int WIDTH = 32
) (
  input  logic                 i_div,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_opnd,
  output logic [2*WIDTH-1:0]   o_acc
);
  logic [WIDTH:0] w_sum, w_diff;
  // divide keeps {remainder, dividend/quotient}; borrow out of the W+1-bit subtract means restore
  always_comb begin
    w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_diff = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opnd};
    o_acc  = !i_div ? {w_sum, i_acc[WIDTH-1:1]} :
             w_diff[WIDTH] ? {i_acc[2*WIDTH-2:0], 1'b0} :
             {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/unidade_multdiv.sv
// unidade_multdiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO
module unidade_multdiv
  import unidade_multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc, w_step, w_prod;
  logic [WIDTH-1:0]   r_opnd, r_hi, r_lo, w_abs_a, w_abs_b, w_q, w_r;
  logic               r_op, r_neg_lo, r_neg_hi, r_done;
  logic               w_mult, w_div, w_go, w_sgn, w_last;
  multdiv_passo #(.WIDTH(WIDTH)) u_passo (
    .i_div (r_op),
    .i_acc (r_acc),
    .i_opnd(r_opnd),
    .o_acc (w_step)
  );
  always_comb begin
    w_mult  = start && (funct == FN_MULT || funct == FN_MULTU);
    w_div   = start && (funct == FN_DIV || funct == FN_DIVU);
    w_go    = w_mult || (w_div && |b);
    w_sgn   = !funct[0];
    w_abs_a = (w_sgn && a[WIDTH-1]) ? -a : a;
    w_abs_b = (w_sgn && b[WIDTH-1]) ? -b : b;
    w_last  = r_cnt == CW'(WIDTH-1);
    w_prod  = r_neg_lo ? -r_acc : r_acc;
    w_q     = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_r     = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk)
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == ST_IDLE ? (w_go ? ST_RUN : ST_IDLE) :
             r_state == ST_RUN ? (w_last ? ST_FIX : ST_RUN) : ST_IDLE;
  always_comb begin
    busy = r_state != ST_IDLE;
    done = r_done;
    hi   = r_hi;
    lo   = r_lo;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_op     <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_go) begin
          r_cnt    <= '0;
          r_op     <= w_div;
          r_acc    <= {{WIDTH{1'b0}}, w_div ? w_abs_a : w_abs_b};
          r_opnd   <= w_div ? w_abs_b : w_abs_a;
          r_neg_lo <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          r_neg_hi <= w_sgn && (w_div ? a[WIDTH-1] : a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (w_div) begin
          r_hi   <= a;
          r_lo   <= '1;
          r_done <= 1'b1;
        end else if (start && funct == FN_MTHI) r_hi <= a;
        else if (start && funct == FN_MTLO) r_lo <= a;
      end else if (r_state == ST_RUN) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_hi   <= r_op ? w_r : w_prod[2*WIDTH-1:WIDTH];
        r_lo   <= r_op ? w_q : w_prod[WIDTH-1:0];
        r_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_unidade_multdiv.sv
// tb_unidade_multdiv: vector table, corner sequences and random ops against an arithmetic model
module tb_unidade_multdiv;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          n_cmp = 0, n_err = 0;
  typedef struct {
    logic [5:0]  f;
    logic [31:0] a, b, hi, lo;
    int          nb, dat;
  } vec_t;
  vec_t v[10];
  logic [5:0] fns[4];
  unidade_multdiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic pulse(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; funct = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  // samples after E0..E39; done_at is the sample index where done was seen
  task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                        output int nb, output int nd, output int done_at);
    pulse(f, x, y);
    nb = 0; nd = 0; done_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (busy) nb++;
      if (done) begin nd++; done_at = c; end
      @(posedge clk); #1;
    end
  endtask
  function automatic void model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] p;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'(x); uy = longint'(y);
    h = '0; l = '0;
    if (f == 6'b011000) begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
    else if (f == 6'b011001) begin p = ux * uy; h = p[63:32]; l = p[31:0]; end
    else if (y == 0) begin h = x; l = '1; end
    else if (f == 6'b011010) begin q = sx / sy; r = sx % sy; h = r[31:0]; l = q[31:0]; end
    else begin uq = ux / uy; ur = ux % uy; h = ur[31:0]; l = uq[31:0]; end
  endfunction
  initial begin
    int nb, nd, da, eb;
    logic [31:0] eh, el, x, y;
    logic [5:0] f;
    v[0] = '{6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 33};
    v[1] = '{6'b011000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 33};
    v[2] = '{6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 33};
    v[3] = '{6'b011011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 0, 0};
    v[4] = '{6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 33};
    v[5] = '{6'b011010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 33};
    v[6] = '{6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, 33, 33};
    v[7] = '{6'b011000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, 33};
    v[8] = '{6'b011010, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0};
    v[9] = '{6'b011011, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 33, 33};
    fns[0] = 6'b011000; fns[1] = 6'b011001; fns[2] = 6'b011010; fns[3] = 6'b011011;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, nb, nd, da);
      chk($sformatf("vec%0d_hi", i), hi, v[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, v[i].lo);
      chk($sformatf("vec%0d_busy", i), nb, v[i].nb);
      chk($sformatf("vec%0d_ndone", i), nd, 32'd1);
      chk($sformatf("vec%0d_done_at", i), da, v[i].dat);
    end
    pulse(6'b010001, 32'hAAAA_AAAA, 32'h0);
    chk("mthi_hi", hi, 32'hAAAA_AAAA);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_done", {31'b0, done}, 32'd0);
    pulse(6'b010011, 32'h1234_5678, 32'h0);
    chk("mtlo_lo", lo, 32'h1234_5678);
    chk("mtlo_hi_kept", hi, 32'hAAAA_AAAA);
    pulse(6'b011011, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    pulse(6'b010011, 32'h5555_5555, 32'h0);
    chk("midrun_busy", {31'b0, busy}, 32'd1);
    chk("midrun_lo", lo, 32'h1234_5678);
    chk("midrun_hi", hi, 32'hAAAA_AAAA);
    repeat (40) @(posedge clk);
    #1;
    chk("divu_after_mt_hi", hi, 32'd2);
    chk("divu_after_mt_lo", lo, 32'd14);
    chk("divu_after_mt_busy", {31'b0, busy}, 32'd0);
    pulse(6'b011000, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_result_hi", hi, 32'd0);
    chk("abort_no_result_lo", lo, 32'd0);
    run_op(6'b011001, 32'd6, 32'd7, nb, nd, da);
    chk("post_abort_lo", lo, 32'd42);
    chk("post_abort_hi", hi, 32'd0);
    chk("post_abort_busy", nb, 32'd33);
    for (int i = 0; i < 40; i++) begin
      f = fns[$urandom_range(0, 3)];
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = y & 32'h0000_00FF;
      if ($urandom_range(0, 7) == 0) y = 32'h0;
      model(f, x, y, eh, el);
      eb = (f[1] && y == 0) ? 0 : 33;
      run_op(f, x, y, nb, nd, da);
      chk($sformatf("rnd%0d_f%b_%h_%h_hi", i, f, x, y), hi, eh);
      chk($sformatf("rnd%0d_f%b_%h_%h_lo", i, f, x, y), lo, el);
      chk($sformatf("rnd%0d_busy", i), nb, eb);
      chk($sformatf("rnd%0d_ndone", i), nd, 32'd1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
